pht_init_ctrl: RTL

- Sequencer and write-port arbiter for the gshare/global-history pattern history table (PHT) in the IFU branch predictor.
- After reset, and on request (e.g. fence.i or a predictor-state flush), it sweeps all 2^k PHT entries to a programmable initial counter value.
- Otherwise it forwards pipeline M-stage direction updates to the PHT write port.
- Asserts Busy so fetch-side logic forces a fixed prediction and ignores PHT read data during the sweep.

---
 rtl/pht_init_ctrl_pkg.sv | 18 +
 rtl/pht_init_ctrl_if.sv | 36 +++
 rtl/pht_sweep_counter.sv | 27 ++
 rtl/pht_init_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/pht_init_ctrl_pkg.sv
// Shared branch-predictor definitions for the PHT initialisation controller:
// FSM state encoding and default table geometry / reset counter value.
package pht_init_ctrl_pkg;

    // START: one settle cycle after reset, SWEEP: table rewrite, IDLE: forward updates
    typedef enum logic [1:0] {
        START = 2'd0,
        SWEEP = 2'd1,
        IDLE  = 2'd2
    } phtStateT;

    // Default PHT index width (depth is 2^k)
    localparam int PHT_K_DEFAULT = 10;

    // Weakly not-taken 2-bit saturating counter
    localparam logic [1:0] PHT_INITVAL_DEFAULT = 2'b01;

endpackage

// File: rtl/pht_init_ctrl_if.sv
// Bus between the IFU pipeline / PHT and the init controller.
// Update side: UpdValid is a request qualified by ~StallW & ~FlushW; there is no
// ready - the controller either forwards a qualified update to the PHT write port
// in the same cycle (IDLE) or discards it and pulses DroppedUpd (START/SWEEP).
interface pht_init_ctrl_if #(
    parameter int k = 10
) ();
    import pht_init_ctrl_pkg::*;

    logic         InitReq;
    logic         StallW;
    logic         FlushW;
    logic         UpdValid;
    logic [k-1:0] UpdIdx;
    logic [1:0]   UpdDir;
    logic         PHTWe;
    logic [k-1:0] PHTWa;
    logic [1:0]   PHTWd;
    logic         Busy;
    logic [1:0]   DirOverride;
    logic         DroppedUpd;
    phtStateT     DbgState;

    // Pipeline / table side
    modport master (
        output InitReq, StallW, FlushW, UpdValid, UpdIdx, UpdDir,
        input  PHTWe, PHTWa, PHTWd, Busy, DirOverride, DroppedUpd, DbgState
    );

    // Controller side
    modport slave (
        input  InitReq, StallW, FlushW, UpdValid, UpdIdx, UpdDir,
        output PHTWe, PHTWa, PHTWd, Busy, DirOverride, DroppedUpd, DbgState
    );

endinterface

// File: rtl/pht_sweep_counter.sv
// k-bit sweep address counter with synchronous clear (priority) and enable.
// Tc flags the last table index so the FSM can leave the sweep.
module pht_sweep_counter #(
    parameter int k = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         Clr,
    input  logic         En,
    output logic [k-1:0] Count,
    output logic         Tc
);

    // Clear beats enable; the increment wraps to 0 after the last index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Count <= '0;
        end else if (Clr) begin
            Count <= '0;
        end else if (En) begin
            Count <= Count + k'(1);
        end
    end

    assign Tc = &Count;

endmodule

// File: rtl/pht_init_ctrl.sv
// PHT initialisation sequencer and write-port arbiter. After reset or on InitReq
// it rewrites every PHT entry with INITVAL, holding Busy high so fetch uses
// DirOverride; otherwise it forwards qualified M-stage updates to the write port.
module pht_init_ctrl
    import pht_init_ctrl_pkg::*;
#(
    parameter int         k       = PHT_K_DEFAULT,
    parameter logic [1:0] INITVAL = PHT_INITVAL_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pht_init_ctrl_if.slave        bus
);

    phtStateT     state;
    logic         busyQ;
    logic [k-1:0] sweepCnt;
    logic         sweepLast;
    logic         cntClr;
    logic         cntEn;
    logic         qualUpd;

    // An update only counts when writeback is neither stalled nor flushed
    assign qualUpd = bus.UpdValid & ~bus.StallW & ~bus.FlushW;

    // Restart clears the address; otherwise advance on every sweep cycle.
    // In IDLE the counter already sits at 0, so no clear is needed there.
    assign cntClr = (state == SWEEP) && bus.InitReq;
    assign cntEn  = (state == SWEEP);

    pht_sweep_counter #(.k(k)) uCnt (
        .clk     (clk),
        .reset_n (reset_n),
        .Clr     (cntClr),
        .En      (cntEn),
        .Count   (sweepCnt),
        .Tc      (sweepLast)
    );

    // Sequencer: START -> SWEEP -> IDLE, with InitReq restarting or re-entering SWEEP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= START;
            busyQ <= 1'b1;
        end else begin
            case (state)
                START: begin
                    // A request here is already covered by the sweep that follows
                    state <= SWEEP;
                    busyQ <= 1'b1;
                end
                SWEEP: begin
                    // Restart outranks completion, even on the last index
                    if (!bus.InitReq && sweepLast) begin
                        state <= IDLE;
                        busyQ <= 1'b0;
                    end else begin
                        state <= SWEEP;
                        busyQ <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.InitReq) begin
                        state <= SWEEP;
                        busyQ <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busyQ <= 1'b0;
                    end
                end
                default: begin
                    state <= START;
                    busyQ <= 1'b1;
                end
            endcase
        end
    end

    // Write-port mux: the sweep always owns the port; pipeline updates pass through only in IDLE
    always_comb begin
        bus.PHTWe      = 1'b0;
        bus.PHTWa      = bus.UpdIdx;
        bus.PHTWd      = bus.UpdDir;
        bus.DroppedUpd = 1'b0;
        case (state)
            START: begin
                bus.DroppedUpd = qualUpd;
            end
            SWEEP: begin
                bus.PHTWe      = 1'b1;
                bus.PHTWa      = sweepCnt;
                bus.PHTWd      = INITVAL;
                bus.DroppedUpd = qualUpd;
            end
            IDLE: begin
                bus.PHTWe      = qualUpd;
            end
            default: begin
                bus.PHTWe      = 1'b0;
            end
        endcase
    end

    assign bus.Busy        = busyQ;
    assign bus.DirOverride = INITVAL;
    assign bus.DbgState    = state;

endmodule
